// File: rtl/hsiao2_pkg.sv
// hsiao2_pkg: event class encoding shared with decoder-side checkers
package hsiao2_pkg;
    typedef enum logic [1:0] {
        EVT_NONE   = 2'd0,
        EVT_CORR   = 2'd1,
        EVT_UNCORR = 2'd2,
        EVT_FATAL  = 2'd3
    } evt_type_t;
endpackage

// File: rtl/hsiao2_evt_fifo.sv
// hsiao2_evt_fifo: synchronous show-ahead FIFO with wrap-bit pointers and flush
module hsiao2_evt_fifo #(
    parameter int W     = 34,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]  wr_ptr, rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push, do_pop;
    assign empty   = wr_ptr == rd_ptr;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // a pop frees the head slot, so a full FIFO still takes a same-cycle push
    assign do_push = push && (!full || do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr[AW-1:0]];
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/hsiao2_64_err_log.sv
// hsiao2_64_err_log: classifies SEC-DED decoder status into counters, irqs and an event FIFO
module hsiao2_64_err_log
    import hsiao2_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int CNT_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_valid,
    input  logic              i_err_corr,
    input  logic              i_err_detec,
    input  logic              i_err_fatal,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic              i_clr,
    input  logic [CNT_W-1:0]  i_corr_thresh,
    output logic [CNT_W-1:0]  o_cnt_corr,
    output logic [CNT_W-1:0]  o_cnt_uncorr,
    output logic              o_irq_corr,
    output logic              o_irq_fatal,
    output logic              o_evt_valid,
    input  logic              i_evt_ready,
    output logic [1:0]        o_evt_type,
    output logic [ADDR_W-1:0] o_evt_addr,
    output logic              o_evt_overflow
);
    evt_type_t           evt;
    logic                push, full, empty, uncorr;
    logic [ADDR_W+1:0]   dout;
    assign evt = !i_valid    ? EVT_NONE :
                 i_err_fatal ? EVT_FATAL :
                 i_err_detec ? EVT_UNCORR :
                 i_err_corr  ? EVT_CORR : EVT_NONE;
    assign uncorr      = evt == EVT_UNCORR || evt == EVT_FATAL;
    assign push        = evt != EVT_NONE && !i_clr;
    assign o_evt_valid = !empty;
    assign o_evt_type  = dout[ADDR_W+1:ADDR_W];
    assign o_evt_addr  = dout[ADDR_W-1:0];
    assign o_irq_corr  = i_corr_thresh != '0 && o_cnt_corr >= i_corr_thresh;
    hsiao2_evt_fifo #(.W(ADDR_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk    (clk),
        .reset_n(reset_n),
        .push   (push),
        .pop    (o_evt_valid && i_evt_ready),
        .flush  (i_clr),
        .din    ({evt, i_addr}),
        .dout   (dout),
        .full   (full),
        .empty  (empty)
    );
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_cnt_corr     <= '0;
            o_cnt_uncorr   <= '0;
            o_irq_fatal    <= 1'b0;
            o_evt_overflow <= 1'b0;
        end else if (i_clr) begin
            o_cnt_corr     <= '0;
            o_cnt_uncorr   <= '0;
            o_irq_fatal    <= 1'b0;
            o_evt_overflow <= 1'b0;
        end else begin
            if (evt == EVT_CORR && o_cnt_corr != '1) o_cnt_corr <= o_cnt_corr + CNT_W'(1);
            if (uncorr && o_cnt_uncorr != '1) o_cnt_uncorr <= o_cnt_uncorr + CNT_W'(1);
            if (uncorr) o_irq_fatal <= 1'b1;
            // full means non-empty, so only a ready consumer can make room
            if (push && full && !i_evt_ready) o_evt_overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_hsiao2_64_err_log.sv
// tb_hsiao2_64_err_log: queue-based reference model plus directed vectors for the error logger
module tb_hsiao2_64_err_log;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int DEPTH  = 8;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic clk = 0, reset_n = 0;
    logic i_valid = 0, i_err_corr = 0, i_err_detec = 0, i_err_fatal = 0, i_clr = 0, i_evt_ready = 0;
    logic [ADDR_W-1:0] i_addr = '0;
    logic [CNT_W-1:0]  i_corr_thresh = '0;
    logic [CNT_W-1:0]  o_cnt_corr, o_cnt_uncorr;
    logic              o_irq_corr, o_irq_fatal, o_evt_valid, o_evt_overflow;
    logic [1:0]        o_evt_type;
    logic [ADDR_W-1:0] o_evt_addr;

    int nchk = 0, nerr = 0;
    int m_corr = 0, m_unc = 0;
    bit m_fat = 0, m_ovf = 0;
    logic [ADDR_W+1:0] q[$];

    always #5 clk = ~clk;

    hsiao2_64_err_log #(.ADDR_W(ADDR_W), .CNT_W(CNT_W), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .i_valid(i_valid), .i_err_corr(i_err_corr),
        .i_err_detec(i_err_detec), .i_err_fatal(i_err_fatal), .i_addr(i_addr), .i_clr(i_clr),
        .i_corr_thresh(i_corr_thresh), .o_cnt_corr(o_cnt_corr), .o_cnt_uncorr(o_cnt_uncorr),
        .o_irq_corr(o_irq_corr), .o_irq_fatal(o_irq_fatal), .o_evt_valid(o_evt_valid),
        .i_evt_ready(i_evt_ready), .o_evt_type(o_evt_type), .o_evt_addr(o_evt_addr),
        .o_evt_overflow(o_evt_overflow)
    );

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // reference model: classify by flag priority, count with saturation, keep a bounded queue
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_corr = 0; m_unc = 0; m_fat = 0; m_ovf = 0; q.delete();
        end else if (i_clr) begin
            m_corr = 0; m_unc = 0; m_fat = 0; m_ovf = 0; q.delete();
        end else begin
            int t, sz;
            bit popped;
            t = !i_valid ? 0 : i_err_fatal ? 3 : i_err_detec ? 2 : i_err_corr ? 1 : 0;
            sz = q.size();
            popped = sz > 0 && i_evt_ready;
            if (popped) void'(q.pop_front());
            if (t == 1 && m_corr < CMAX) m_corr++;
            if (t >= 2) begin
                if (m_unc < CMAX) m_unc++;
                m_fat = 1;
            end
            if (t != 0) begin
                if (sz < DEPTH || popped) q.push_back({t[1:0], i_addr});
                else m_ovf = 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [ADDR_W+1:0] head;
        head = q.size() > 0 ? q[0] : '0;
        chk("cnt_corr", o_cnt_corr, m_corr);
        chk("cnt_uncorr", o_cnt_uncorr, m_unc);
        chk("irq_corr", o_irq_corr, i_corr_thresh != 0 && m_corr >= i_corr_thresh);
        chk("irq_fatal", o_irq_fatal, m_fat);
        chk("evt_valid", o_evt_valid, q.size() > 0);
        chk("evt_type", o_evt_type, head[ADDR_W+1:ADDR_W]);
        chk("evt_addr", o_evt_addr, head[ADDR_W-1:0]);
        chk("overflow", o_evt_overflow, m_ovf);
    end

    task automatic drive(input logic v, input logic c, input logic d, input logic f,
                         input logic [ADDR_W-1:0] a, input logic rdy, input logic clr);
        i_valid = v; i_err_corr = c; i_err_detec = d; i_err_fatal = f;
        i_addr = a; i_evt_ready = rdy; i_clr = clr;
        @(posedge clk); #1;
        i_valid = 0; i_err_corr = 0; i_err_detec = 0; i_err_fatal = 0; i_clr = 0;
    endtask

    initial begin
        int pops;
        for (int i = 0; i < 4; i++) drive(1, i[0], i[1], 1, 32'h100 + i, i[0], 0);
        chk("rst_cnt_corr", o_cnt_corr, 0);
        chk("rst_evt_valid", o_evt_valid, 0);
        reset_n = 1;
        for (int i = 0; i < 5; i++) drive(1, 0, 0, 0, 32'h200 + i, 0, 0);
        chk("noflag_cnt", {o_cnt_corr, o_cnt_uncorr}, 0);
        chk("noflag_valid", o_evt_valid, 0);

        drive(1, 1, 0, 0, 32'h1000, 0, 0);
        chk("lat_valid", o_evt_valid, 1);
        drive(1, 0, 1, 0, 32'h50000, 0, 0);
        drive(1, 0, 1, 1, 32'hB0000, 0, 0);
        chk("seq_cnt_corr", o_cnt_corr, 1);
        chk("seq_cnt_uncorr", o_cnt_uncorr, 2);
        chk("seq_irq_fatal", o_irq_fatal, 1);
        chk("head0", {o_evt_type, o_evt_addr}, {2'd1, 32'h1000});
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("head1", {o_evt_type, o_evt_addr}, {2'd2, 32'h50000});
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("head2", {o_evt_type, o_evt_addr}, {2'd3, 32'hB0000});
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("drained", {o_evt_valid, o_evt_type, o_evt_addr}, 0);

        drive(0, 0, 0, 0, 0, 0, 1);
        i_corr_thresh = 3;
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 0, 0, 32'h3000 + i, 1, 0);
            if (i == 1) chk("irq_before3", o_irq_corr, 0);
            if (i == 2) chk("irq_at3", o_irq_corr, 1);
        end
        i_corr_thresh = 0;
        #1 chk("irq_disable", o_irq_corr, 0);
        @(posedge clk); #1;

        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) drive(1, 1, 0, 0, 32'h4000 + i, 0, 0);
        chk("ovf_flag", o_evt_overflow, 1);
        chk("ovf_cnt", o_cnt_corr, 9);
        chk("ovf_head", o_evt_addr, 32'h4000);
        drive(1, 1, 0, 0, 32'h4009, 1, 0);
        chk("full_pop_push_head", o_evt_addr, 32'h4001);
        pops = 0;
        while (o_evt_valid && pops < 20) begin
            drive(0, 0, 0, 0, 0, 1, 0);
            pops++;
        end
        chk("ovf_depth", pops, 8);

        drive(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 20; i++) drive(1, 1, 0, 0, 32'h6000 + i, 1, 0);
        chk("sat_corr", o_cnt_corr, 15);

        drive(1, 0, 1, 0, 32'h7000, 0, 0);
        chk("pre_clr_valid", o_evt_valid, 1);
        drive(1, 0, 1, 0, 32'h7004, 1, 1);
        chk("clr_all", {o_cnt_corr, o_cnt_uncorr, o_irq_fatal, o_evt_overflow, o_evt_valid}, 0);
        drive(0, 0, 0, 0, 0, 1, 0);
        chk("clr_stays_empty", o_evt_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
